// File: rtl/sao_pkg.sv
// Shared types for SAO edge-offset statistics: EO categories, accumulator FSM
// states and default accumulator widths.
package sao_pkg;

  localparam int CNT_W_DEF = 13;
  localparam int SUM_W_DEF = 18;

  typedef enum logic [2:0] {
    CAT0 = 3'd0,
    CAT1 = 3'd1,
    CAT2 = 3'd2,
    CAT3 = 3'd3,
    CAT4 = 3'd4
  } eo_cat_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DUMP = 2'd2
  } state_e;

endpackage

// File: rtl/sao_eo_classify.sv
// Combinational edge-offset classifier: two neighbour signs -> EO category.
// Shared with the SAO apply stage.
module sao_eo_classify
  import sao_pkg::*;
(
  input  logic signed [1:0] i_sign_l,
  input  logic signed [1:0] i_sign_r,
  output eo_cat_e           o_cat
);

  // Code 2'b10 has no valid meaning as a sign; fold it onto -1.
  function automatic logic signed [2:0] sign_val(input logic signed [1:0] s);
    case (s)
      2'sb01:  return 3'sd1;
      2'sb00:  return 3'sd0;
      default: return -3'sd1;
    endcase
  endfunction

  logic signed [2:0] w_edge;

  always_comb begin
    w_edge = sign_val(i_sign_l) + sign_val(i_sign_r);
    case (w_edge)
      -3'sd2:  o_cat = CAT1;
      -3'sd1:  o_cat = CAT2;
      3'sd1:   o_cat = CAT3;
      3'sd2:   o_cat = CAT4;
      default: o_cat = CAT0;
    endcase
  end

endmodule

// File: rtl/sao_eo_stat_accum.sv
// Per-CTU SAO edge-offset statistics: accumulates clipped diff sums and pixel
// counts for categories 1..4, then hands out the four results one per handshake.
module sao_eo_stat_accum
  import sao_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SUM_W     = SUM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    ctu_start,
  input  logic                    ctu_last,
  input  logic signed [1:0]       sign_l,
  input  logic signed [1:0]       sign_r,
  input  logic signed [4:0]       diff,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              out_cat,
  output logic signed [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0]        out_cnt,
  output logic                    err
);

  // diff arrives pre-clipped to 5 bits, so BIT_DEPTH only bounds legal configs.
  if (BIT_DEPTH < 1 || SUM_W < 6 || CNT_W < 1) begin : g_param_chk
    $error("sao_eo_stat_accum: illegal parameter combination");
  end

  state_e                  r_state;
  eo_cat_e                 r_idx;
  logic                    r_err;
  logic signed [SUM_W-1:0] r_sum [1:4];
  logic [CNT_W-1:0]        r_cnt [1:4];

  eo_cat_e                 w_cat;
  logic                    w_acc;
  logic                    w_clr;
  logic                    w_add;
  logic                    w_done;
  logic                    w_sat;
  logic                    w_proto_err;
  logic signed [SUM_W-1:0] w_sum_nxt [1:4];
  logic [CNT_W-1:0]        w_cnt_nxt [1:4];

  function automatic logic signed [SUM_W:0] sum_wide(input logic signed [SUM_W-1:0] a,
                                                     input logic signed [4:0] d);
    return {a[SUM_W-1], a} + {{(SUM_W-4){d[4]}}, d};
  endfunction

  function automatic logic sum_ovf(input logic signed [SUM_W:0] s);
    return s[SUM_W] != s[SUM_W-1];
  endfunction

  function automatic logic signed [SUM_W-1:0] sum_sat(input logic signed [SUM_W:0] s);
    if (!sum_ovf(s)) return s[SUM_W-1:0];
    return s[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
  endfunction

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  sao_eo_classify u_classify (
    .i_sign_l (sign_l),
    .i_sign_r (sign_r),
    .o_cat    (w_cat)
  );

  always_comb begin
    w_acc       = in_valid && in_ready;
    w_clr       = w_acc && ctu_start;
    w_add       = w_acc && (ctu_start || (r_state == ST_ACC));
    w_done      = (r_state == ST_DUMP) && out_ready && (r_idx == CAT4);
    w_proto_err = w_acc && (((r_state == ST_IDLE) && !ctu_start) ||
                            ((r_state == ST_ACC) && ctu_start));
    w_sat       = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      w_sum_nxt[c] = r_sum[c];
      w_cnt_nxt[c] = r_cnt[c];
      if (w_clr || w_done) begin
        w_sum_nxt[c] = '0;
        w_cnt_nxt[c] = '0;
      end
      // A restart clears first, so the restarting pixel lands on a clean slate.
      if (w_add && (w_cat == eo_cat_e'(c))) begin
        w_sat = w_sat | sum_ovf(sum_wide(w_sum_nxt[c], diff)) | (&w_cnt_nxt[c]);
        w_sum_nxt[c] = sum_sat(sum_wide(w_sum_nxt[c], diff));
        w_cnt_nxt[c] = cnt_sat_inc(w_cnt_nxt[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= CAT1;
      r_err   <= 1'b0;
      for (int c = 1; c <= 4; c++) begin
        r_sum[c] <= '0;
        r_cnt[c] <= '0;
      end
    end else begin
      r_sum <= w_sum_nxt;
      r_cnt <= w_cnt_nxt;
      if (w_sat || w_proto_err) r_err <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_clr) r_state <= ctu_last ? ST_DUMP : ST_ACC;
        ST_ACC:  if (w_acc && ctu_last) r_state <= ST_DUMP;
        ST_DUMP: begin
          if (out_ready) begin
            if (r_idx == CAT4) begin
              r_idx   <= CAT1;
              r_state <= ST_IDLE;
            end else begin
              r_idx <= eo_cat_e'(r_idx + 3'd1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state != ST_DUMP);
  assign out_valid = (r_state == ST_DUMP);
  assign out_cat   = r_idx;
  assign out_sum   = r_sum[r_idx];
  assign out_cnt   = r_cnt[r_idx];
  assign err       = r_err;

endmodule

// File: doc/sao_eo_stat_accum.md
SAO_EO_STAT_ACCUM -- requirements
Module: sao_eo_stat_accum

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, sample bit depth (informational; diff is already clipped upstream).
REQ-002 SHALL have parameter CNT_W, default 13, per-category pixel count width (64x64 CTU = 4096 max).
REQ-003 SHALL have parameter SUM_W, default 18, signed per-category diff sum width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  pixel statistic valid.
REQ-007 in_ready  out  1  block can accept a pixel.
REQ-008 ctu_start  in  1  first pixel of CTU, qualified by in_valid.
REQ-009 ctu_last  in  1  last pixel of CTU, qualified by in_valid.
REQ-010 sign_l  in  2  signed sign(rec_m - rec_l): -1/0/+1.
REQ-011 sign_r  in  2  signed sign(rec_m - rec_r): -1/0/+1.
REQ-012 diff  in  5  signed clipped org-rec, range -16..15.
REQ-013 out_valid  out  1  category result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 out_cat  out  3  EO category 1..4.
REQ-016 out_sum  out  SUM_W  signed diff sum for out_cat.
REQ-017 out_cnt  out  CNT_W  pixel count for out_cat.
REQ-018 err  out  1  sticky protocol error.

Function
REQ-019 Pixel accepted iff in_valid && in_ready at a rising clk edge.
REQ-020 edge = sign_l + sign_r; -2 -> cat1, -1 -> cat2, 0 -> cat0 (no stats), +1 -> cat3, +2 -> cat4; sign code 2'b10 SHALL be treated as -1.
REQ-021 On acceptance, for cat1..4: sum[cat] += sign-extended diff, cnt[cat] += 1, updated at the same edge; cat0 pixels change no accumulator.
REQ-022 FSM states IDLE, ACC, DUMP; in_ready = 1 in IDLE and ACC, 0 in DUMP.
REQ-023 IDLE: accepted pixel with ctu_start -> load it as the sole contribution (all other accumulators 0) and go ACC; accepted pixel without ctu_start is dropped and sets err.
REQ-024 ACC: accepted ctu_start SHALL restart (clear, then count that pixel) and set err; accepted ctu_last -> DUMP with index 1, pixel included.
REQ-025 ctu_start and ctu_last on the same accepted pixel: one-pixel CTU, accumulate then go DUMP.
REQ-026 DUMP: out_valid = 1; out_cat/out_sum/out_cnt show current index; outputs SHALL hold stable while out_valid && !out_ready.
REQ-027 Each out_valid && out_ready advances index 1->2->3->4; acceptance of cat4 clears all accumulators and returns to IDLE; exactly 4 results per CTU.
REQ-028 Latency: first result valid the cycle after ctu_last acceptance; zero-stall dump takes 4 cycles; next CTU accepted the cycle after cat4 handshake.
REQ-029 cnt SHALL saturate at 2^CNT_W-1 and sum SHALL saturate at signed SUM_W limits, each setting err.
REQ-030 err clears only on reset.

Reset
REQ-031 rst_n low asynchronously forces IDLE, all accumulators 0, index 1, out_valid 0, out_cat 1, out_sum 0, out_cnt 0, err 0; in_ready SHALL read 1 during and after reset.
REQ-032 Reset mid-ACC or mid-DUMP SHALL discard partial statistics; no result emitted.
REQ-033 Deassertion SHALL take effect synchronously at the first clk edge with rst_n high (caller synchronizes release).

Structure
REQ-034 sao_pkg SHALL hold the eo_cat_e enum (CAT0..CAT4), the FSM state enum, and the CNT_W/SUM_W defaults.
REQ-035 Classification SHALL be a combinational sub-module sao_eo_classify (sign_l, sign_r -> eo_cat_e), reusable by the SAO apply stage.
REQ-036 Accumulators SHALL be arrays indexed by category 1..4; no memories.

Verification
REQ-037 CTU of 4 pixels (start on first, last on fourth), (sign_l,sign_r,diff) = (-1,-1,5),(-1,0,-3),(1,1,15),(0,0,7) -> results cat1 sum5 cnt1, cat2 -3/1, cat3 0/0, cat4 15/1.
REQ-038 4096 pixels all (-1,-1,-16) -> cat1 sum -65536 cnt 4096, other categories 0, err 0.
REQ-039 out_ready low 3 cycles during cat2 -> outputs hold stable, in_ready 0 throughout, cat3 appears one cycle after the handshake.
REQ-040 Single pixel with start+last, (1,0,-2) -> cat3 sum -2 cnt 1; a pixel without ctu_start in IDLE -> err 1, no effect on results.
REQ-041 rst_n pulsed low mid-ACC after 10 pixels -> out_valid 0; following CTU results exclude the earlier pixels.
